nexys4_seven_segment_scanner: RTL and testbench

Time-multiplexed driver for the Nexys4 eight-digit common-anode seven-segment display. It supplies the `seg`/`dp`/`an` pins that the board top currently ties off. It accepts a 32-bit hex value, per-digit decimal points and a per-digit enable mask, and scans one digit per slot. Inputs are latched once per frame so the display never shows a torn value.

---
 rtl/nexys4_seven_segment_scanner.sv | 122 ++++++++++++
 tb/tb_nexys4_seven_segment_scanner.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/nexys4_seven_segment_scanner.sv
`default_nettype none
// ============================================================================
// Module   : nexys4_seven_segment_scanner
// Brief    : Eight-digit common-anode seven-segment scanner with per-frame
//            input snapshot, per-digit enable/decimal point and blanking gap.
// Revision : 1.0 - initial release
// ============================================================================
module nexys4_seven_segment_scanner #(
    parameter int DIGIT_PERIOD = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] number,
    input  logic [7:0]  dots,
    input  logic [7:0]  enable,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [7:0]  an,
    output logic        frame_done
);

    localparam int                 c_CNT_W   = (DIGIT_PERIOD > 1) ? $clog2(DIGIT_PERIOD) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DIGIT_PERIOD - 1);
    localparam logic [c_CNT_W-1:0] c_BLANK   = c_CNT_W'(BLANK_CYCLES);

    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]         r_idx;
    logic [31:0]        r_num_sh;
    logic [7:0]         r_dots_sh;
    logic [7:0]         r_en_sh;
    logic [6:0]         r_seg;
    logic               r_dp;
    logic [7:0]         r_an;
    logic               r_frame_done;

    logic               w_slot_end;
    logic               w_capture;
    logic               w_active;
    logic [3:0]         w_nibble;
    logic [6:0]         w_glyph;

    assign w_slot_end = (r_cnt == c_CNT_MAX);
    assign w_capture  = w_slot_end && (r_idx == 3'd7);
    assign w_active   = (r_cnt >= c_BLANK) && r_en_sh[r_idx];
    assign w_nibble   = r_num_sh[{r_idx, 2'b00} +: 4];

    // Active-low segment pattern, bit 0 = a ... bit 6 = g.
    always_comb begin
        w_glyph = 7'h7F;
        case (w_nibble)
            4'h0: w_glyph = 7'h40;
            4'h1: w_glyph = 7'h79;
            4'h2: w_glyph = 7'h24;
            4'h3: w_glyph = 7'h30;
            4'h4: w_glyph = 7'h19;
            4'h5: w_glyph = 7'h12;
            4'h6: w_glyph = 7'h02;
            4'h7: w_glyph = 7'h78;
            4'h8: w_glyph = 7'h00;
            4'h9: w_glyph = 7'h10;
            4'hA: w_glyph = 7'h08;
            4'hB: w_glyph = 7'h03;
            4'hC: w_glyph = 7'h46;
            4'hD: w_glyph = 7'h21;
            4'hE: w_glyph = 7'h06;
            4'hF: w_glyph = 7'h0E;
            default: w_glyph = 7'h7F;
        endcase
    end

    // Slot/digit sequencing and the end-of-frame snapshot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_idx     <= 3'd0;
            r_num_sh  <= 32'h0;
            r_dots_sh <= 8'h0;
            r_en_sh   <= 8'h0;
        end else begin
            if (w_slot_end) begin
                r_cnt <= '0;
                r_idx <= r_idx + 3'd1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_capture) begin
                r_num_sh  <= number;
                r_dots_sh <= dots;
                r_en_sh   <= enable;
            end
        end
    end

    // Registered pin drivers; inactive digits leave every anode off.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_seg        <= 7'h7F;
            r_dp         <= 1'b1;
            r_an         <= 8'hFF;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_capture;
            if (w_active) begin
                r_seg <= w_glyph;
                r_dp  <= ~r_dots_sh[r_idx];
                r_an  <= ~(8'h01 << r_idx);
            end else begin
                r_seg <= 7'h7F;
                r_dp  <= 1'b1;
                r_an  <= 8'hFF;
            end
        end
    end

    assign seg        = r_seg;
    assign dp         = r_dp;
    assign an         = r_an;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_nexys4_seven_segment_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_nexys4_seven_segment_scanner
// Brief    : Self-checking bench: vector table, corner sequences, random run
//            against a time-indexed reference model of the scanner.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nexys4_seven_segment_scanner;

    localparam int DP    = 8;
    localparam int BLANK = 2;
    localparam int FRAME = 8 * DP;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] number = 32'h0;
    logic [7:0]  dots = 8'h0;
    logic [7:0]  enable = 8'h0;
    logic [6:0]  seg;
    logic        dp;
    logic [7:0]  an;
    logic        frame_done;

    nexys4_seven_segment_scanner #(
        .DIGIT_PERIOD(DP),
        .BLANK_CYCLES(BLANK)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .number    (number),
        .dots      (dots),
        .enable    (enable),
        .seg       (seg),
        .dp        (dp),
        .an        (an),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: output is a pure function of elapsed cycles since
    // reset and the snapshot taken at the last end-of-frame.
    logic [6:0]  hex_tab [16];
    logic [31:0] m_num = 0;
    logic [7:0]  m_dots = 0;
    logic [7:0]  m_en = 0;
    logic [6:0]  exp_seg = 7'h7F;
    logic        exp_dp = 1'b1;
    logic [7:0]  exp_an = 8'hFF;
    logic        exp_fd = 1'b0;
    logic        m_lit;
    int          t = 0;
    int          pos, md, mc;
    int          rst_gen = 0;

    initial begin
        hex_tab[0]  = 7'h40; hex_tab[1]  = 7'h79; hex_tab[2]  = 7'h24; hex_tab[3]  = 7'h30;
        hex_tab[4]  = 7'h19; hex_tab[5]  = 7'h12; hex_tab[6]  = 7'h02; hex_tab[7]  = 7'h78;
        hex_tab[8]  = 7'h00; hex_tab[9]  = 7'h10; hex_tab[10] = 7'h08; hex_tab[11] = 7'h03;
        hex_tab[12] = 7'h46; hex_tab[13] = 7'h21; hex_tab[14] = 7'h06; hex_tab[15] = 7'h0E;
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            t = 0; m_num = 0; m_dots = 0; m_en = 0;
            exp_seg = 7'h7F; exp_dp = 1'b1; exp_an = 8'hFF; exp_fd = 1'b0;
            rst_gen++;
        end else begin
            pos = t % FRAME;
            md  = pos / DP;
            mc  = pos % DP;
            m_lit   = (mc >= BLANK) && m_en[md];
            exp_an  = m_lit ? ~(8'd1 << md) : 8'hFF;
            exp_seg = m_lit ? hex_tab[m_num[4*md +: 4]] : 7'h7F;
            exp_dp  = m_lit ? ~m_dots[md] : 1'b1;
            exp_fd  = (pos == FRAME - 1);
            if (pos == FRAME - 1) begin
                m_num = number; m_dots = dots; m_en = enable;
            end
            t++;
        end
    end

    // Cycle-by-cycle monitor: model agreement, one-hot anodes, frame period.
    int cyc = 0;
    int last_fd = -1;
    int seen_gen = 0;
    always @(negedge clk) begin
        cyc++;
        if (seen_gen != rst_gen) begin
            seen_gen = rst_gen;
            last_fd  = -1;
        end
        check("mdl_seg", 32'(seg), 32'(exp_seg));
        check("mdl_dp", 32'(dp), 32'(exp_dp));
        check("mdl_an", 32'(an), 32'(exp_an));
        check("mdl_frame_done", 32'(frame_done), 32'(exp_fd));
        check("an_onehot", 32'($countones(~an) <= 1), 32'd1);
        if (frame_done === 1'b1) begin
            if (last_fd >= 0) check("fd_interval", 32'(cyc - last_fd), 32'(FRAME));
            last_fd = cyc;
        end
    end

    task automatic wait_fd();
        logic found = 1'b0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge clk);
            if (frame_done === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        check("fd_timeout", 32'(found), 32'd1);
    endtask

    // Cycles from reset release to the first frame_done; anodes must stay off.
    task automatic count_blank_frame(input string name);
        int   n = 0;
        logic dark = 1'b1;
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge clk);
            n++;
            if (an !== 8'hFF) dark = 1'b0;
            if (frame_done === 1'b1) break;
        end
        check({name, "_fd_cycle"}, 32'(n), 32'(FRAME));
        check({name, "_blank"}, 32'(dark), 32'd1);
    endtask

    typedef struct {
        logic [31:0] num;
        logic [7:0]  dts;
        logic [7:0]  en;
        int          digit;
        logic [7:0]  x_an;
        logic [6:0]  x_seg;
        logic        x_dp;
    } vec_t;

    vec_t vecs [16];

    initial begin
        vecs[0]  = '{32'h89ABCDEF, 8'h00, 8'hFF, 0, 8'hFE, 7'h0E, 1'b1};
        vecs[1]  = '{32'h89ABCDEF, 8'h00, 8'hFF, 1, 8'hFD, 7'h06, 1'b1};
        vecs[2]  = '{32'h89ABCDEF, 8'h00, 8'hFF, 2, 8'hFB, 7'h21, 1'b1};
        vecs[3]  = '{32'h89ABCDEF, 8'h00, 8'hFF, 3, 8'hF7, 7'h46, 1'b1};
        vecs[4]  = '{32'h89ABCDEF, 8'h00, 8'hFF, 4, 8'hEF, 7'h03, 1'b1};
        vecs[5]  = '{32'h89ABCDEF, 8'h00, 8'hFF, 5, 8'hDF, 7'h08, 1'b1};
        vecs[6]  = '{32'h89ABCDEF, 8'h00, 8'hFF, 6, 8'hBF, 7'h10, 1'b1};
        vecs[7]  = '{32'h89ABCDEF, 8'h00, 8'hFF, 7, 8'h7F, 7'h00, 1'b1};
        vecs[8]  = '{32'h00000321, 8'h04, 8'h05, 0, 8'hFE, 7'h79, 1'b1};
        vecs[9]  = '{32'h00000321, 8'h04, 8'h05, 1, 8'hFF, 7'h7F, 1'b1};
        vecs[10] = '{32'h00000321, 8'h04, 8'h05, 2, 8'hFB, 7'h30, 1'b0};
        vecs[11] = '{32'h00000321, 8'h04, 8'h05, 3, 8'hFF, 7'h7F, 1'b1};
        vecs[12] = '{32'h01234567, 8'hFF, 8'hFF, 7, 8'h7F, 7'h40, 1'b0};
        vecs[13] = '{32'h01234567, 8'hFF, 8'hFF, 4, 8'hEF, 7'h30, 1'b0};
        vecs[14] = '{32'hFFFFFFFF, 8'h80, 8'h7F, 7, 8'hFF, 7'h7F, 1'b1};
        vecs[15] = '{32'hFFFFFFFF, 8'h80, 8'h7F, 6, 8'hBF, 7'h0E, 1'b1};

        // Reset held with random inputs.
        number = $urandom; dots = 8'($urandom); enable = 8'($urandom);
        repeat (3) @(negedge clk);
        check("rst_an", 32'(an), 32'hFF);
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_dp", 32'(dp), 32'd1);
        check("rst_fd", 32'(frame_done), 32'd0);
        reset = 1'b0;
        count_blank_frame("rst");

        // Vector table: each record gets its own captured frame.
        foreach (vecs[k]) begin
            number = vecs[k].num; dots = vecs[k].dts; enable = vecs[k].en;
            wait_fd();
            repeat (DP * vecs[k].digit + 1) @(negedge clk);
            for (int c = 0; c < DP; c++) begin
                check($sformatf("vec%0d_c%0d_an", k, c), 32'(an), (c < BLANK) ? 32'hFF : 32'(vecs[k].x_an));
                check($sformatf("vec%0d_c%0d_seg", k, c), 32'(seg), (c < BLANK) ? 32'h7F : 32'(vecs[k].x_seg));
                check($sformatf("vec%0d_c%0d_dp", k, c), 32'(dp), (c < BLANK) ? 32'd1 : 32'(vecs[k].x_dp));
                @(negedge clk);
            end
        end

        // Tear-free update: change mid-frame, new value only after frame_done.
        number = 32'h11111111; dots = 8'h00; enable = 8'hFF;
        wait_fd();
        repeat (DP * 3 + 4) @(negedge clk);
        number = 32'h22222222;
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (an !== 8'hFF) check("tear_old_seg", 32'(seg), 32'h79);
            if (frame_done === 1'b1) break;
            @(negedge clk);
        end
        repeat (BLANK + 1) @(negedge clk);
        check("tear_new_an", 32'(an), 32'hFE);
        check("tear_new_seg", 32'(seg), 32'h24);

        // Asynchronous reset while digit 5 is lit.
        wait_fd();
        repeat (DP * 5 + 4) @(negedge clk);
        check("mid_pre_an", 32'(an), 32'hDF);
        #2 reset = 1'b1;
        #1;
        check("mid_async_an", 32'(an), 32'hFF);
        check("mid_async_seg", 32'(seg), 32'h7F);
        check("mid_async_dp", 32'(dp), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        count_blank_frame("mid");
        repeat (BLANK + 1) @(negedge clk);
        check("mid_resume_an", 32'(an), 32'hFE);
        check("mid_resume_seg", 32'(seg), 32'h24);

        // Randomized inputs, checked cycle by cycle by the monitor.
        for (int i = 0; i < 20 * FRAME; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) number = $urandom;
            if ($urandom_range(0, 7) == 0) dots   = 8'($urandom);
            if ($urandom_range(0, 7) == 0) enable = 8'($urandom);
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
